// File: rtl/uart_ctrl_rx.sv
// UART 8N1 receiver with keyboard command decode into held paddle levels and a start pulse.
// Direction outputs are held by per-player down-counters that each matching byte reloads.
module uart_ctrl_rx #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int HOLD_MS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_trigger,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int HOLD_CYCLES  = (CLK_HZ / 1000) * HOLD_MS;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int HOLD_W       = $clog2(HOLD_CYCLES);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_P1_UP,
        CMD_P1_DN,
        CMD_P2_UP,
        CMD_P2_DN,
        CMD_START
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        case (b)
            8'h77, 8'h57: c = CMD_P1_UP;
            8'h73, 8'h53: c = CMD_P1_DN;
            8'h69, 8'h49: c = CMD_P2_UP;
            8'h6B, 8'h4B: c = CMD_P2_DN;
            8'h20, 8'h0D: c = CMD_START;
            default:      c = CMD_NONE;
        endcase
        return c;
    endfunction

    logic              r_sync1;
    logic              r_rx_s;
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_wait_high;
    logic [7:0]        r_rx_byte;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_start_trig;
    logic              r_p1_up;
    logic              r_p1_down;
    logic              r_p2_up;
    logic              r_p2_down;
    logic [HOLD_W-1:0] r_p1_tmr;
    logic [HOLD_W-1:0] r_p2_tmr;

    cmd_t w_cmd_new;
    cmd_t w_cmd_out;
    logic w_stop_ok;
    logic w_p1_reload;
    logic w_p2_reload;

    assign w_cmd_new   = decode_cmd(r_shift);
    assign w_cmd_out   = decode_cmd(r_rx_byte);
    assign w_stop_ok   = (r_state == S_STOP) && (r_baud_cnt == BIT_LAST) && r_rx_s;
    assign w_p1_reload = r_rx_valid && ((w_cmd_out == CMD_P1_UP) || (w_cmd_out == CMD_P1_DN));
    assign w_p2_reload = r_rx_valid && ((w_cmd_out == CMD_P2_UP) || (w_cmd_out == CMD_P2_DN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_wait_high  <= 1'b0;
            r_rx_byte    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_start_trig <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_start_trig <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                    // After a bad stop bit the line must go high again before a new start counts.
                    if (r_wait_high) begin
                        if (r_rx_s) begin
                            r_wait_high <= 1'b0;
                        end
                    end else if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud_cnt == HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_state    <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        if (r_rx_s) begin
                            r_rx_byte    <= r_shift;
                            r_rx_valid   <= 1'b1;
                            r_start_trig <= (w_cmd_new == CMD_START);
                        end else begin
                            r_frame_err <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Levels rise together with rx_valid; the timer is loaded in the rx_valid cycle so the
    // level stays up for exactly HOLD_CYCLES cycles counted from rx_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_up   <= 1'b0;
            r_p1_down <= 1'b0;
            r_p2_up   <= 1'b0;
            r_p2_down <= 1'b0;
            r_p1_tmr  <= '0;
            r_p2_tmr  <= '0;
        end else begin
            if (w_p1_reload) begin
                r_p1_tmr <= HOLD_LOAD;
            end else if (r_p1_tmr != HOLD_ZERO) begin
                r_p1_tmr <= r_p1_tmr - HOLD_ONE;
            end
            if (w_p2_reload) begin
                r_p2_tmr <= HOLD_LOAD;
            end else if (r_p2_tmr != HOLD_ZERO) begin
                r_p2_tmr <= r_p2_tmr - HOLD_ONE;
            end

            if (w_stop_ok && (w_cmd_new == CMD_P1_UP)) begin
                r_p1_up   <= 1'b1;
                r_p1_down <= 1'b0;
            end else if (w_stop_ok && (w_cmd_new == CMD_P1_DN)) begin
                r_p1_up   <= 1'b0;
                r_p1_down <= 1'b1;
            end else if ((r_p1_tmr == HOLD_ONE) && !w_p1_reload) begin
                r_p1_up   <= 1'b0;
                r_p1_down <= 1'b0;
            end

            if (w_stop_ok && (w_cmd_new == CMD_P2_UP)) begin
                r_p2_up   <= 1'b1;
                r_p2_down <= 1'b0;
            end else if (w_stop_ok && (w_cmd_new == CMD_P2_DN)) begin
                r_p2_up   <= 1'b0;
                r_p2_down <= 1'b1;
            end else if ((r_p2_tmr == HOLD_ONE) && !w_p2_reload) begin
                r_p2_up   <= 1'b0;
                r_p2_down <= 1'b0;
            end
        end
    end

    assign p1_up         = r_p1_up;
    assign p1_down       = r_p1_down;
    assign p2_up         = r_p2_up;
    assign p2_down       = r_p2_down;
    assign start_trigger = r_start_trig;
    assign rx_byte       = r_rx_byte;
    assign rx_valid      = r_rx_valid;
    assign frame_err     = r_frame_err;

endmodule
